// File: rtl/cam_pkg.sv
// Shared types and constants for the RGB byte-to-word assembler.
// Holds the assembly state encoding, the byte lane indices and the default pad byte.
// The pack_word helper places the R, G and B bytes into their lanes below the pad byte.
package cam_pkg;

    typedef enum logic [1:0] {
        EXP_R = 2'd0,
        EXP_G = 2'd1,
        EXP_B = 2'd2
    } state_t;

    // Byte lane of each colour inside the 24-bit pixel part of the word
    localparam int IDX_R = 2;
    localparam int IDX_G = 1;
    localparam int IDX_B = 0;

    localparam logic [7:0] DEF_PAD_BYTE = 8'h00;

    function automatic logic [31:0] pack_word(input logic [7:0] pad,
                                              input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
        logic [31:0] w;
        w                  = '0;
        w[31:24]           = pad;
        w[IDX_R*8 +: 8]    = r;
        w[IDX_G*8 +: 8]    = g;
        w[IDX_B*8 +: 8]    = b;
        return w;
    endfunction

endpackage

// File: rtl/cam_word_fifo.sv
// Word buffer: DEPTH-entry FIFO with a combinational head output (zero when empty).
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: a push on full is accepted only if a pop happens in the same cycle; clear wins over both.
module cam_word_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] rd_dat_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o   = (cnt_q == FULL_CNT);
    assign empty_o  = (cnt_q == '0);
    assign do_pop   = pop_i & ~empty_o & ~clear_i;
    // On full, the slot being popped this cycle is the one the push reuses
    assign do_push  = push_i & (~full_o | do_pop) & ~clear_i;
    assign rd_dat_o = empty_o ? '0 : mem_q[rptr_q];

    // Storage array: written on accepted pushes only, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clear_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cam_bytes_to_word.sv
// Assembles R,G,B byte stream into {PAD_BYTE,R,G,B} words; optional framing check via CAM_B2W_ALIGN_CHECK_EN.
// Latency: word appears on out_word one cycle after its B byte; one word per 3 valid bytes sustained.
// Backpressure: none on input; a word arriving on a full buffer without a same-cycle pop is dropped and flags overflow.
module cam_bytes_to_word
    import cam_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE  = DEF_PAD_BYTE,
    parameter int         BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_byte_valid,
    input  logic        in_word_last,
    input  logic        clear,
    output logic [31:0] out_word,
    output logic        out_word_valid,
    input  logic        out_word_ready,
    output logic        overflow,
    output logic        align_err,
    output logic [7:0]  err_count
);

    state_t      state_q;
    logic [7:0]  r_q;
    logic [7:0]  g_q;
    logic        overflow_q;
    logic        frame_err;
    logic        push_req;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [31:0] fifo_head;

`ifdef CAM_B2W_ALIGN_CHECK_EN
    logic        align_err_q;
    logic [7:0]  err_cnt_q;

    // Marker must be set exactly on the B byte
    assign frame_err = in_byte_valid &
                       ((state_q == EXP_B) ? ~in_word_last : in_word_last);

    // Registered error pulse and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            align_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else if (clear) begin
            align_err_q <= 1'b0;
            err_cnt_q   <= 8'h00;
        end else begin
            align_err_q <= frame_err;
            if (frame_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign align_err = align_err_q;
    assign err_count = err_cnt_q;
`else
    logic unused_last;

    assign unused_last = in_word_last;
    assign frame_err   = 1'b0;
    assign align_err   = 1'b0;
    assign err_count   = 8'h00;
`endif

    assign push_req = in_byte_valid & (state_q == EXP_B) & ~frame_err & ~clear;
    assign pop      = out_word_valid & out_word_ready;

    // Assembly FSM: latch R and G, return to EXP_R after B or on a framing error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EXP_R;
            r_q     <= 8'h00;
            g_q     <= 8'h00;
        end else if (clear) begin
            state_q <= EXP_R;
        end else if (in_byte_valid) begin
            case (state_q)
                EXP_R: begin
                    if (!frame_err) begin
                        r_q     <= in_byte;
                        state_q <= EXP_G;
                    end
                end
                EXP_G: begin
                    if (frame_err) begin
                        state_q <= EXP_R;
                    end else begin
                        g_q     <= in_byte;
                        state_q <= EXP_B;
                    end
                end
                default: state_q <= EXP_R;
            endcase
        end
    end

    // Sticky overflow: a word was lost because the buffer stayed full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (clear) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow_q <= 1'b1;
        end
    end

    cam_word_fifo #(
        .W     (32),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .push_i     (push_req),
        .push_dat_i (pack_word(PAD_BYTE, r_q, g_q, in_byte)),
        .pop_i      (pop),
        .rd_dat_o   (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign out_word       = fifo_head;
    assign out_word_valid = ~fifo_empty;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_cam_bytes_to_word.sv
// Directed bench for cam_bytes_to_word with default parameters (PAD_BYTE=00, BUF_DEPTH=2).
// Inputs change 1ns after posedge; outputs are sampled there, reflecting the preceding edge.
// Framing-check scenarios follow the CAM_B2W_ALIGN_CHECK_EN build of the design.
module tb_cam_bytes_to_word;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_byte_valid;
    logic        in_word_last;
    logic        clear;
    logic [31:0] out_word;
    logic        out_word_valid;
    logic        out_word_ready;
    logic        overflow;
    logic        align_err;
    logic [7:0]  err_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cam_bytes_to_word dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_byte        (in_byte),
        .in_byte_valid  (in_byte_valid),
        .in_word_last   (in_word_last),
        .clear          (clear),
        .out_word       (out_word),
        .out_word_valid (out_word_valid),
        .out_word_ready (out_word_ready),
        .overflow       (overflow),
        .align_err      (align_err),
        .err_count      (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        in_byte       = b;
        in_byte_valid = 1'b1;
        in_word_last  = last;
        tick();
        in_byte_valid = 1'b0;
        in_word_last  = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        in_byte        = 8'h00;
        in_byte_valid  = 1'b0;
        in_word_last   = 1'b0;
        clear          = 1'b0;
        out_word_ready = 1'b0;
        #12;
        tests++;
        if (out_word !== 32'h0 || out_word_valid !== 1'b0 || overflow !== 1'b0 ||
            align_err !== 1'b0 || err_count !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: word=%h vld=%b ovf=%b aerr=%b cnt=%h, want 0", out_word,
                     out_word_valid, overflow, align_err, err_count);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        out_word_ready = 1'b1;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        tests++;
        if (out_word_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_early: vld=%b want 0 after G byte", out_word_valid);
        end
        send_byte(8'h33, 1'b1);
        tests++;
        if (out_word_valid !== 1'b1 || out_word !== 32'h00112233) begin
            fails++;
            $display("FAIL basic_word: vld=%b word=%h want 1 00112233", out_word_valid, out_word);
        end
        tick();
        tests++;
        if (out_word_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_pop: vld=%b want 0", out_word_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_word_ready = 1'b1;
        send_byte(8'hD1, 1'b0);
        send_byte(8'hD2, 1'b0);
        send_byte(8'hD3, 1'b1);
        tests++;
        if (out_word !== 32'h00D1D2D3 || out_word_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_w0: vld=%b word=%h want 1 00D1D2D3", out_word_valid, out_word);
        end
        send_byte(8'hE1, 1'b0);
        tests++;
        if (out_word_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_gap: vld=%b want 0", out_word_valid);
        end
        send_byte(8'hE2, 1'b0);
        send_byte(8'hE3, 1'b1);
        tests++;
        if (out_word !== 32'h00E1E2E3 || out_word_valid !== 1'b1) begin
            fails++;
            $display("FAIL b2b_w1: vld=%b word=%h want 1 00E1E2E3", out_word_valid, out_word);
        end
        tick();
    endtask

    task automatic test_overflow();
        out_word_ready = 1'b0;
        send_byte(8'hA1, 1'b0); send_byte(8'hA2, 1'b0); send_byte(8'hA3, 1'b1);
        send_byte(8'hB1, 1'b0); send_byte(8'hB2, 1'b0); send_byte(8'hB3, 1'b1);
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_early: ovf=%b want 0 with buffer just full", overflow);
        end
        send_byte(8'hC1, 1'b0); send_byte(8'hC2, 1'b0); send_byte(8'hC3, 1'b1);
        tick();
        tick();
        tests++;
        if (overflow !== 1'b1 || out_word_valid !== 1'b1 || out_word !== 32'h00A1A2A3) begin
            fails++;
            $display("FAIL ovf_hold: ovf=%b vld=%b word=%h want 1 1 00A1A2A3", overflow,
                     out_word_valid, out_word);
        end
        out_word_ready = 1'b1;
        tick();
        tests++;
        if (out_word_valid !== 1'b1 || out_word !== 32'h00B1B2B3) begin
            fails++;
            $display("FAIL ovf_second: vld=%b word=%h want 1 00B1B2B3", out_word_valid, out_word);
        end
        tick();
        tests++;
        if (out_word_valid !== 1'b0 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_drain: vld=%b ovf=%b want 0 1 (third word dropped, flag sticky)",
                     out_word_valid, overflow);
        end
        do_clear();
        tests++;
        if (overflow !== 1'b0) begin
            fails++;
            $display("FAIL ovf_clear: ovf=%b want 0", overflow);
        end
    endtask

    task automatic test_push_pop_full();
        out_word_ready = 1'b0;
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b0); send_byte(8'h05, 1'b0); send_byte(8'h06, 1'b1);
        send_byte(8'h07, 1'b0); send_byte(8'h08, 1'b0);
        out_word_ready = 1'b1;
        send_byte(8'h09, 1'b1);
        out_word_ready = 1'b0;
        tests++;
        if (out_word !== 32'h00040506 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_pushpop: word=%h ovf=%b want 00040506 0", out_word, overflow);
        end
        tick();
        tests++;
        if (out_word !== 32'h00040506 || out_word_valid !== 1'b1) begin
            fails++;
            $display("FAIL full_stall: word=%h vld=%b want 00040506 1", out_word, out_word_valid);
        end
        out_word_ready = 1'b1;
        tick();
        tests++;
        if (out_word !== 32'h00070809 || out_word_valid !== 1'b1) begin
            fails++;
            $display("FAIL full_third: word=%h vld=%b want 00070809 1", out_word, out_word_valid);
        end
        tick();
        tests++;
        if (out_word_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_empty: vld=%b want 0", out_word_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_word_ready = 1'b1;
        send_byte(8'h77, 1'b0);
        send_byte(8'h88, 1'b0);
        #2 rst_n = 1'b0;
        #2;
        tests++;
        if (out_word_valid !== 1'b0 || out_word !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_out: vld=%b word=%h want 0 0", out_word_valid, out_word);
        end
        #3 rst_n = 1'b1;
        tick();
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b1);
        tests++;
        if (out_word !== 32'h00445566 || out_word_valid !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_word: vld=%b word=%h want 1 00445566", out_word_valid, out_word);
        end
        tick();
    endtask

    task automatic test_clear();
        out_word_ready = 1'b0;
        send_byte(8'h10, 1'b0); send_byte(8'h20, 1'b0); send_byte(8'h30, 1'b1);
        send_byte(8'h40, 1'b0); send_byte(8'h50, 1'b0); send_byte(8'h60, 1'b1);
        send_byte(8'h70, 1'b0); send_byte(8'h80, 1'b0); send_byte(8'h90, 1'b1);
        send_byte(8'hA0, 1'b0); send_byte(8'hB0, 1'b0);
        clear = 1'b1;
        send_byte(8'hC0, 1'b1);
        clear = 1'b0;
        tests++;
        if (out_word_valid !== 1'b0 || overflow !== 1'b0 || err_count !== 8'h00) begin
            fails++;
            $display("FAIL clear_full: vld=%b ovf=%b cnt=%h want 0 0 00", out_word_valid,
                     overflow, err_count);
        end
        out_word_ready = 1'b1;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        tests++;
        if (out_word !== 32'h00010203 || out_word_valid !== 1'b1) begin
            fails++;
            $display("FAIL clear_after: vld=%b word=%h want 1 00010203", out_word_valid, out_word);
        end
        tick();
    endtask

`ifdef CAM_B2W_ALIGN_CHECK_EN
    task automatic test_align();
        out_word_ready = 1'b1;
        do_clear();
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        tests++;
        if (align_err !== 1'b1 || err_count !== 8'd1 || out_word_valid !== 1'b0) begin
            fails++;
            $display("FAIL align_pulse: aerr=%b cnt=%h vld=%b want 1 01 0", align_err,
                     err_count, out_word_valid);
        end
        send_byte(8'h01, 1'b0);
        tests++;
        if (align_err !== 1'b0) begin
            fails++;
            $display("FAIL align_once: aerr=%b want 0", align_err);
        end
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b1);
        tests++;
        if (out_word !== 32'h00010203 || out_word_valid !== 1'b1 || err_count !== 8'd1) begin
            fails++;
            $display("FAIL align_word: vld=%b word=%h cnt=%h want 1 00010203 01",
                     out_word_valid, out_word, err_count);
        end
        tick();
        for (int i = 0; i < 253; i++) send_byte(8'h5A, 1'b1);
        tests++;
        if (err_count !== 8'hFE) begin
            fails++;
            $display("FAIL align_cnt254: cnt=%h want FE", err_count);
        end
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5A, 1'b1);
        send_byte(8'h5A, 1'b1);
        tests++;
        if (err_count !== 8'hFF) begin
            fails++;
            $display("FAIL align_sat: cnt=%h want FF", err_count);
        end
        do_clear();
        tests++;
        if (err_count !== 8'h00) begin
            fails++;
            $display("FAIL align_clear: cnt=%h want 00", err_count);
        end
    endtask
`else
    task automatic test_align();
        out_word_ready = 1'b1;
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        tests++;
        if (align_err !== 1'b0 || err_count !== 8'h00) begin
            fails++;
            $display("FAIL noalign_flags: aerr=%b cnt=%h want 0 00", align_err, err_count);
        end
        send_byte(8'hCC, 1'b0);
        tests++;
        if (out_word !== 32'h00AABBCC || out_word_valid !== 1'b1) begin
            fails++;
            $display("FAIL noalign_word: vld=%b word=%h want 1 00AABBCC", out_word_valid, out_word);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_reset_mid();
        test_clear();
        test_align();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cam_bytes_to_word.md
CAM_BYTES_TO_WORD -- requirements
Module: cam_bytes_to_word

Interface
REQ-001 SHALL have parameter PAD_BYTE, default 8'h00, the value placed in out_word[31:24].
REQ-002 SHALL have parameter BUF_DEPTH, default 2, the number of output word-buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port in_byte, input, 8, the byte-stream data in R,G,B order.
REQ-006 SHALL have port in_byte_valid, input, 1, qualifying in_byte; there is no input backpressure.
REQ-007 SHALL have port in_word_last, input, 1, the sender's marker on the B byte of each word.
REQ-008 SHALL have port clear, input, 1, a synchronous flush of the assembly state, the buffer and the flags.
REQ-009 SHALL have port out_word, output, 32, the assembled word {PAD_BYTE,R,G,B}.
REQ-010 SHALL have port out_word_valid, output, 1, asserted when the buffer is non-empty.
REQ-011 SHALL have port out_word_ready, input, 1, the consumer accept; a pop occurs when valid and ready are both high.
REQ-012 SHALL have port overflow, output, 1, a sticky flag for a word dropped on a full buffer.
REQ-013 SHALL have port align_err, output, 1, a one-cycle pulse on a framing error.
REQ-014 SHALL have port err_count, output, 8, the saturating count of align_err pulses.

Function
REQ-015 SHALL implement assembly FSM states EXP_R, EXP_G, EXP_B; valid bytes advance EXP_R->EXP_G->EXP_B->EXP_R, and invalid cycles hold the state.
REQ-016 SHALL latch the byte in EXP_R as R and in EXP_G as G; on a valid byte in EXP_B, SHALL form {PAD_BYTE,R,G,in_byte} and push it.
REQ-017 SHALL present a pushed word on out_word/out_word_valid the cycle after the B byte (latency 1), FIFO-ordered.
REQ-018 SHALL allow push and pop in the same cycle at any occupancy, including full, with no loss.
REQ-019 SHALL drop the new word and set overflow when the buffer is full with no same-cycle pop; the FSM still returns to EXP_R.
REQ-020 SHALL hold out_word stable while out_word_valid=1 and out_word_ready=0.
REQ-021 SHALL, when clear=1, return the FSM to EXP_R, empty the buffer, and zero overflow and err_count; clear has priority over every same-cycle push or pop.
REQ-022 SHALL accept a byte every cycle: sustained rate is one word per 3 valid bytes.

Reset
REQ-023 SHALL on rst_n=0, asynchronously: FSM=EXP_R, buffer empty, out_word=32'h0, out_word_valid=0, overflow=0, align_err=0, err_count=0.
REQ-024 SHALL discard any partial word or buffered word when reset is asserted mid-operation; the first byte after deassertion is treated as R.

Configuration
REQ-025 SHALL, with CAM_B2W_ALIGN_CHECK_EN defined, treat in_word_last=1 on a valid byte in EXP_R or EXP_G, or in_word_last=0 on a valid byte in EXP_B, as a framing error: discard the partial word, go to EXP_R, pulse align_err, and increment err_count, saturating at 8'hFF.
REQ-026 SHALL, without CAM_B2W_ALIGN_CHECK_EN, ignore in_word_last and tie align_err=0 and err_count=8'h00.

Structure
REQ-027 SHALL place the FSM state enum, the byte-index constants (R=2, G=1, B=0) and the default PAD_BYTE in shared package cam_pkg.
REQ-028 SHALL implement the output buffer as sub-module cam_word_fifo (BUF_DEPTH entries, push/pop, full/empty).

Verification
REQ-029 SHALL cover back-to-back bytes 11,22,33 (last on 33), ready=1 -> out_word=32'h00112233, valid one cycle after 33.
REQ-030 SHALL cover ready=0 while 3 words arrive with BUF_DEPTH=2 -> first two words are retained, the third is dropped, overflow=1, and ready=1 then yields the two words in order.
REQ-031 SHALL cover, with the macro defined, bytes AA,BB(last=1) then 01,02,03(last on 03) -> align_err pulses once, err_count=1, out_word=32'h00010203 only.
REQ-032 SHALL cover reset asserted after R,G -> no output, and the next 44,55,66 yields 32'h00445566.
REQ-033 SHALL cover clear coinciding with the B byte while the buffer is full -> buffer empty, no word, overflow=0, err_count=0.
REQ-034 SHALL cover 256 forced framing errors -> err_count saturates at 8'hFF.
